clkenunit: RTL
==============

Name: clkenunit

Overview:
- Parametrised successor to the board clock unit. All timing is generated as single-cycle tick enables in one clock domain (clk_in), with no derived or gated clocks.
- Tick sources: a runtime-programmable divider, a synchronised external pulse input, and a debounced push button.
- Source changes are hitless: a guard interval prevents runt or double ticks.
- Feeds the PWM and step logic through tick_out, and status/diagnostics through sel_active, switching and tick_cnt.

Parameters:
- DIV_W, 24, width of the divisor register and counter.
- DIV_RST, 500000, divisor after reset (100 Hz ticks from 50 MHz).
- DEB_CYCLES, 500000, consecutive stable cycles required to accept a new button level; legal range 1 to 2^20.
- GUARD, 2, tick-suppression cycles on a source switch; minimum 1.
- CNT_W, 16, width of tick_cnt.

Ports:
- clk_in  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous assert, active-low
- ext_in  in  1  external pulse, asynchronous to clk_in
- btn_in  in  1  raw push button, asynchronous, bouncy
- src_sel  in  2  source select: 00 = divider, 01 = ext, 10 = button, 11 = off
- div_val  in  DIV_W  new divisor value
- div_load  in  1  one-cycle strobe that captures div_val
- tick_out  out  1  one-cycle tick enable from the active source
- sel_active  out  2  source currently driving tick_out
- switching  out  1  high while the FSM is in state SWITCH
- tick_cnt  out  CNT_W  count of tick_out pulses, wraps modulo 2^CNT_W

Behaviour:

Reset:
- Asynchronous assert, synchronous release. Everything returns to reset values immediately, including mid-operation.
- Reset values: tick_out = 0, sel_active = 00, switching = 0, tick_cnt = 0, state RUN.
- Internal: div_reg = DIV_RST, counter = DIV_RST-1, synchronisers = 0, debounced level = 0, debounce counter = 0.

ext path:
- 2-FF synchroniser, then a rising-edge detector produces ext_tick.
- Latency is 3 clk_in cycles from the ext_in rise to ext_tick.
- Pulses narrower than one clk_in period may be lost; this is not an error.

btn path:
- 2-FF synchroniser feeds the debouncer.
- Debounce counter clears whenever the synced level equals the debounced level.
- When they differ, the counter increments. At DEB_CYCLES the debounced level flips and the counter clears.
- A rising edge of the debounced level produces btn_tick for one cycle. Falling edges produce nothing.

Divider:
- div_load captures div_val into div_reg.
- The new value takes effect at the next terminal count. The current period is never truncated.
- The counter counts down and emits div_tick when it equals 0, then reloads div_reg-1.
- div_reg = 1 gives a tick every cycle.
- div_reg = 0 halts the divider: counter held at 0, no div_tick. When a nonzero value is later loaded while halted, it is applied immediately as a reload of div_reg-1.
- div_load in the same cycle as the terminal count: the tick still fires and the reload uses the new value.

Switch FSM:
- Registers src_q = src_sel each cycle.
- RUN:
  - tick_out = tick of sel_active (off gives 0), registered, one cycle after the source tick.
  - If src_q differs from sel_active, go to SWITCH and set guard_cnt = GUARD-1.
- SWITCH:
  - switching = 1; tick_out forced to 0. Ticks from any source are dropped.
  - The divider counter is held at div_reg-1.
  - If src_q changes during SWITCH, guard_cnt restarts at GUARD-1 (last value wins).
  - When guard_cnt = 0, set sel_active = src_q and return to RUN. The divider counter starts counting from this cycle.
  - Result: the first divider tick after a switch to 00 arrives exactly div_reg cycles after RUN re-entry.
- Ticks from non-selected sources are discarded. The ext and btn paths keep running regardless of selection.

tick_cnt:
- Increments on every tick_out and wraps from 2^CNT_W-1 to 0.
- It is not cleared by a source switch, only by reset.

Test Plan:
1. Divider: DIV_RST = 5, src_sel = 00, release reset -> first tick_out at cycle 5 after release, then every 5 cycles; tick_cnt = 4 after 20 cycles.
2. Reload: with divisor 5, pulse div_load with div_val = 3 mid-period -> current 5-cycle period completes, following periods are 3; div_val = 0 -> ticks stop, counter holds; div_val = 2 -> ticks every 2 cycles.
3. ext: src_sel = 01, drive ext_in high for 4 cycles at arbitrary phase, repeated 10 times -> exactly 10 tick_out pulses, each 4 cycles after its rising edge (3 sync/edge + 1 output register).
4. btn: DEB_CYCLES = 8, src_sel = 10, bounce btn_in (1,0,1,0 at 2-cycle spacing) then hold high 20 cycles -> exactly one tick_out; bounce on release -> no tick.
5. Switch: GUARD = 2, DIV_RST = 4, switch 00 -> 01 while ext pulses arrive -> switching high for 2 cycles, no tick_out in the guard; change src_sel again during the guard -> guard restarts and sel_active = final value.
6. Reset: assert rst_n low mid-SWITCH and mid-debounce -> all outputs go to reset values asynchronously; CNT_W = 4 run of 17 ticks -> tick_cnt = 1 (wrap).

Source files
------------

// File: rtl/clkenunit.sv
`default_nettype none
// ============================================================================
// Module      : clkenunit
// Description : Single-domain tick-enable generator. Selects one of three tick
//               sources (programmable divider, synchronised external pulse,
//               debounced push button) and emits one-cycle enables on
//               tick_out. A guard interval on every source change prevents
//               runt or double ticks.
// Ports       : clk_in     - system clock
//               rst_n      - asynchronous active-low reset, synchronous release
//               ext_in     - asynchronous external pulse
//               btn_in     - asynchronous, bouncy push button
//               src_sel    - 00 divider, 01 ext, 10 button, 11 off
//               div_val    - new divisor value
//               div_load   - one-cycle strobe capturing div_val
//               tick_out   - one-cycle tick enable from the active source
//               sel_active - source currently driving tick_out
//               switching  - high while the guard interval is running
//               tick_cnt   - wrapping count of tick_out pulses
// Revision    : 1.0 - initial release
// ============================================================================
module clkenunit #(
    parameter int DIV_W      = 24,
    parameter int DIV_RST    = 500000,
    parameter int DEB_CYCLES = 500000,
    parameter int GUARD      = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             ext_in,
    input  logic             btn_in,
    input  logic [1:0]       src_sel,
    input  logic [DIV_W-1:0] div_val,
    input  logic             div_load,
    output logic             tick_out,
    output logic [1:0]       sel_active,
    output logic             switching,
    output logic [CNT_W-1:0] tick_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_deb_w = $clog2(DEB_CYCLES + 1);
    localparam int c_grd_w = (GUARD > 1) ? $clog2(GUARD) : 1;

    localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);
    localparam logic [c_grd_w-1:0] c_grd_init = c_grd_w'(GUARD - 1);
    localparam logic [DIV_W-1:0]   c_div_rst  = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0]   c_cnt_rst  = (DIV_RST == 0) ? '0 : DIV_W'(DIV_RST - 1);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_SWITCH = 1'b1
    } state_t;

    state_t r_state;

    // ------------------------------------------------------------------------
    // External pulse: 2-FF synchroniser plus registered rising-edge detector
    // ------------------------------------------------------------------------
    logic r_ext_s1;
    logic r_ext_s2;
    logic r_ext_s3;
    logic r_ext_tick;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_ext_s1   <= 1'b0;
            r_ext_s2   <= 1'b0;
            r_ext_s3   <= 1'b0;
            r_ext_tick <= 1'b0;
        end else begin
            r_ext_s1   <= ext_in;
            r_ext_s2   <= r_ext_s1;
            r_ext_s3   <= r_ext_s2;
            r_ext_tick <= r_ext_s2 & ~r_ext_s3;
        end
    end

    // ------------------------------------------------------------------------
    // Push button: 2-FF synchroniser plus debouncer. A new level is accepted
    // only after DEB_CYCLES consecutive cycles that disagree with the current
    // debounced level; any agreeing cycle restarts the count.
    // ------------------------------------------------------------------------
    logic               r_btn_s1;
    logic               r_btn_s2;
    logic               r_btn_deb;
    logic [c_deb_w-1:0] r_deb_cnt;
    logic               r_btn_tick;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s1   <= 1'b0;
            r_btn_s2   <= 1'b0;
            r_btn_deb  <= 1'b0;
            r_deb_cnt  <= '0;
            r_btn_tick <= 1'b0;
        end else begin
            r_btn_s1   <= btn_in;
            r_btn_s2   <= r_btn_s1;
            r_btn_tick <= 1'b0;
            if (r_btn_s2 == r_btn_deb) begin
                r_deb_cnt <= '0;
            end else if (r_deb_cnt == c_deb_last) begin
                r_btn_deb  <= r_btn_s2;
                r_deb_cnt  <= '0;
                // only a press (new level 1) produces a tick
                r_btn_tick <= r_btn_s2;
            end else begin
                r_deb_cnt <= r_deb_cnt + c_deb_w'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Programmable divider. A loaded divisor only matters at the next reload,
    // so the running period is never cut short. A zero divisor parks the
    // counter at 0 with r_div_halt set; because a halted counter sits at its
    // reload point, a later nonzero load restarts it immediately.
    // ------------------------------------------------------------------------
    logic [DIV_W-1:0] r_div_reg;
    logic [DIV_W-1:0] r_div_cnt;
    logic             r_div_halt;
    logic [DIV_W-1:0] w_div_eff;
    logic [DIV_W-1:0] w_div_reload;
    logic             w_div_tick;

    always_comb begin
        w_div_eff    = div_load ? div_val : r_div_reg;
        w_div_reload = (w_div_eff == '0) ? '0 : (w_div_eff - DIV_W'(1));
        w_div_tick   = (r_div_cnt == '0) && !r_div_halt;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_div_reg  <= c_div_rst;
            r_div_cnt  <= c_cnt_rst;
            r_div_halt <= (DIV_RST == 0);
        end else begin
            if (div_load) begin
                r_div_reg <= div_val;
            end
            // During the guard the counter is parked at a full period so the
            // first divider tick lands exactly div_reg cycles after RUN resumes.
            if ((r_state == ST_SWITCH) || (r_div_cnt == '0)) begin
                r_div_cnt  <= w_div_reload;
                r_div_halt <= (w_div_eff == '0);
            end else begin
                r_div_cnt <= r_div_cnt - DIV_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Source multiplexer
    // ------------------------------------------------------------------------
    logic [1:0] r_sel;
    logic       w_src_tick;

    always_comb begin
        w_src_tick = 1'b0;
        case (r_sel)
            2'b00:   w_src_tick = w_div_tick;
            2'b01:   w_src_tick = r_ext_tick;
            2'b10:   w_src_tick = r_btn_tick;
            default: w_src_tick = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------------
    // Switch FSM with registered outputs and the tick counter
    // ------------------------------------------------------------------------
    logic [1:0]         r_src_q;
    logic [1:0]         r_src_qq;
    logic [c_grd_w-1:0] r_guard;
    logic               r_switching;
    logic               r_tick;
    logic [CNT_W-1:0]   r_tick_cnt;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_src_q     <= 2'b00;
            r_src_qq    <= 2'b00;
            r_sel       <= 2'b00;
            r_guard     <= '0;
            r_switching <= 1'b0;
            r_tick      <= 1'b0;
            r_tick_cnt  <= '0;
        end else begin
            r_src_q  <= src_sel;
            r_src_qq <= r_src_q;
            case (r_state)
                ST_RUN: begin
                    r_tick <= w_src_tick;
                    if (w_src_tick) begin
                        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
                    end
                    if (r_src_q != r_sel) begin
                        r_state     <= ST_SWITCH;
                        r_switching <= 1'b1;
                        r_guard     <= c_grd_init;
                    end
                end
                ST_SWITCH: begin
                    r_tick <= 1'b0;
                    // a further select change restarts the guard so the last
                    // requested source is the one that ends up active
                    if (r_src_q != r_src_qq) begin
                        r_guard <= c_grd_init;
                    end else if (r_guard == '0) begin
                        r_sel       <= r_src_q;
                        r_state     <= ST_RUN;
                        r_switching <= 1'b0;
                    end else begin
                        r_guard <= r_guard - c_grd_w'(1);
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_switching <= 1'b0;
                    r_tick      <= 1'b0;
                end
            endcase
        end
    end

    assign tick_out   = r_tick;
    assign sel_active = r_sel;
    assign switching  = r_switching;
    assign tick_cnt   = r_tick_cnt;

endmodule
`default_nettype wire
